algo_rd_scoreboard: RTL
=======================

# algo_rd_scoreboard

Parametrised read-data scoreboard for the multi-port memory algorithm IPs. It monitors N read ports and M write ports and keeps a shadow memory with per-entry written bits. Each read is checked for the return-valid strobe and for data at a fixed configurable latency. It sits beside the algorithm top (bound or instantiated in the verification wrapper) and reports sticky error flags, saturating counters and a first-error capture, so a failure can be located without waveform digging.

## Interface
- NUMRDPT, 2, number of read ports
- NUMWRPT, 1, number of write ports
- WIDTH, 32, data width
- NUMADDR, 8192, logical address depth
- BITADDR, 13, address width
- RD_DELAY, 2, read latency in cycles; must be at least 1
- CNTW, 16, error counter width
- clk  in  1  clock; all logic rises on posedge
- rst  in  1  reset; asynchronous, active-low
- ready  in  1  the IP has finished initialisation
- read  in  NUMRDPT  read request per port
- rd_adr  in  NUMRDPT*BITADDR  read address; port p uses slice p
- rd_vld  in  NUMRDPT  read-return valid
- rd_dout  in  NUMRDPT*WIDTH  read-return data
- rd_serr  in  NUMRDPT  single-bit error, corrected
- rd_derr  in  NUMRDPT  double-bit error, uncorrectable
- write  in  NUMWRPT  write request per port
- wr_adr  in  NUMWRPT*BITADDR  write address
- din  in  NUMWRPT*WIDTH  write data
- req_err  out  1  sticky flag: a request was issued while ready=0
- vld_err  out  NUMRDPT  sticky, per port: rd_vld did not match the expected strobe
- dat_err  out  NUMRDPT  sticky, per port: data miscompare
- err_cnt  out  CNTW  total error events; saturates at all-ones
- first_vld  out  1  first-error capture is valid
- first_port  out  clog2(NUMRDPT), minimum 1  port of the first error
- first_adr  out  BITADDR  address of the first error

## Operation
- Shadow memory: NUMADDR x WIDTH data array plus a written bit per entry. All written bits are cleared on reset.
- Write commit:
  - A write with ready=1 stores din and sets the written bit.
  - If several write ports hit the same address in one cycle, the highest-indexed port wins.
- Read issue:
  - A read with ready=1 pushes {valid, addr, expected data, expected-known} into that port's RD_DELAY-deep pipe.
  - Expected data is sampled from the shadow memory before any same-cycle write commits. A same-cycle write to the same address is therefore not visible to that read.
  - Reads with out-of-range addresses (>= NUMADDR) push expected-known=0.
- Check at pipe output, per port:
  - If pipe valid differs from rd_vld, raise vld_err.
  - If pipe valid, rd_vld, expected-known, and rd_derr=0, then rd_dout must equal the expected data; otherwise raise dat_err.
  - rd_serr does not suppress the compare.
  - rd_derr with valid data is not an error.
- Protocol: read or write asserted while ready=0 sets req_err. The request is still ignored for shadow and pipe purposes.
- err_cnt adds the number of error events in a cycle: popcount of new vld and dat mismatches plus a req violation. It saturates and never wraps.
- First-error capture:
  - Latched on the first cycle with any error while first_vld=0; first_vld then holds 1.
  - The lowest-indexed failing port wins.
  - A req-only error captures port 0 and the address of the lowest asserted request.

## Timing
- Reset (async assert, sync deassert): all sticky flags, err_cnt, first_* and pipe valids are 0.
- A read at cycle t expects rd_vld at t+RD_DELAY. Flags and counters update registered at t+RD_DELAY+1.
- A write at t is visible to reads issued at t+1.
- req_err sets at t+1 after the offending request.
- Reset asserted mid-operation drops all in-flight pipe entries. Returns arriving after reset release with no matching pipe entry raise vld_err.
- Back-to-back reads on every port every cycle are supported with no bubbles.

## Structure
- Package algo_rd_scoreboard_pkg holds the error event type (NONE, VLD, DAT, REQ), the pipe entry struct and the saturating add function.
- One sub-module, algo_rd_scoreboard_pipe: a single-port RD_DELAY shift pipe with async reset on the valid bits, instantiated NUMRDPT times.
- Shadow memory is a plain register array inside the top.

## Test plan
- Write 0x1234_5678 to address 5 at t0, read it on port 1 at t1 with RD_DELAY=2; return the same data at t3 -> no flags, err_cnt=0.
- Read address 5 on port 0 at t; rd_vld rises one cycle late -> vld_err[0]=1, err_cnt=2 (missing and unexpected strobe), first_port=0, first_adr=5.
- Return 0x1234_5679 for address 5 with rd_serr=1 -> dat_err=1; repeat with rd_derr=1 -> no dat_err.
- Same cycle: write 0xAA to address 7 and read address 7; return the old value 0x55 -> pass; return 0xAA -> dat_err.
- NUMWRPT=2, both ports write address 3 (0x11 on port 0, 0x22 on port 1); a later read returns 0x22 -> pass.
- Force a persistent miscompare with CNTW=4 -> err_cnt stops at 15. Assert rst mid-burst -> all outputs are 0 immediately.

Source files
------------

// File: rtl/algo_rd_scoreboard_pkg.sv
// Shared types and helpers for the read-data scoreboard: error event kinds,
// the control half of a pipe entry and a saturating adder for the error counter.
package algo_rd_scoreboard_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_VLD  = 2'd1,
        EV_DAT  = 2'd2,
        EV_REQ  = 2'd3
    } err_ev_e;

    // Address and data ride alongside in parameter-sized vectors.
    typedef struct packed {
        logic vld;
        logic known;
    } pipe_ctl_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/algo_rd_scoreboard_pipe.sv
// One read port's expectation pipe: RD_DELAY stages of {valid, known, addr, data};
// only the control bits are reset so in-flight entries vanish on reset.
module algo_rd_scoreboard_pipe
    import algo_rd_scoreboard_pkg::*;
#(
    parameter int RD_DELAY = 2,
    parameter int BITADDR  = 13,
    parameter int WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               known_i,
    input  logic [BITADDR-1:0] adr_i,
    input  logic [WIDTH-1:0]   dat_i,
    output logic               vld_o,
    output logic               known_o,
    output logic [BITADDR-1:0] adr_o,
    output logic [WIDTH-1:0]   dat_o
);

    pipe_ctl_t          ctl_q [RD_DELAY];
    logic [BITADDR-1:0] adr_q [RD_DELAY];
    logic [WIDTH-1:0]   dat_q [RD_DELAY];

    genvar gi;
    generate
        for (gi = 0; gi < RD_DELAY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) ctl_q[gi] <= '0;
                    else      ctl_q[gi] <= '{vld: push_i, known: known_i};
                end
                always_ff @(posedge clk) begin
                    adr_q[gi] <= adr_i;
                    dat_q[gi] <= dat_i;
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) ctl_q[gi] <= '0;
                    else      ctl_q[gi] <= ctl_q[gi-1];
                end
                always_ff @(posedge clk) begin
                    adr_q[gi] <= adr_q[gi-1];
                    dat_q[gi] <= dat_q[gi-1];
                end
            end
        end
    endgenerate

    assign vld_o   = ctl_q[RD_DELAY-1].vld;
    assign known_o = ctl_q[RD_DELAY-1].known;
    assign adr_o   = adr_q[RD_DELAY-1];
    assign dat_o   = dat_q[RD_DELAY-1];

endmodule

// File: rtl/algo_rd_scoreboard.sv
// Read-data scoreboard: shadow memory with written bits, per-port latency pipes,
// sticky flags, a saturating error counter and first-error capture.
module algo_rd_scoreboard
    import algo_rd_scoreboard_pkg::*;
#(
    parameter int NUMRDPT  = 2,
    parameter int NUMWRPT  = 1,
    parameter int WIDTH    = 32,
    parameter int NUMADDR  = 8192,
    parameter int BITADDR  = 13,
    parameter int RD_DELAY = 2,
    parameter int CNTW     = 16,
    localparam int FPW     = (NUMRDPT > 1) ? $clog2(NUMRDPT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMRDPT-1:0]         read,
    input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
    input  logic [NUMRDPT-1:0]         rd_vld,
    input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    input  logic [NUMRDPT-1:0]         rd_serr,
    input  logic [NUMRDPT-1:0]         rd_derr,
    input  logic [NUMWRPT-1:0]         write,
    input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
    input  logic [NUMWRPT*WIDTH-1:0]   din,
    output logic                       req_err,
    output logic [NUMRDPT-1:0]         vld_err,
    output logic [NUMRDPT-1:0]         dat_err,
    output logic [CNTW-1:0]            err_cnt,
    output logic                       first_vld,
    output logic [FPW-1:0]             first_port,
    output logic [BITADDR-1:0]         first_adr
);

    logic [WIDTH-1:0]   mem_q [NUMADDR];
    logic [NUMADDR-1:0] written_q;

    logic [NUMRDPT-1:0] push, exp_known, pq_vld, pq_known;
    logic [WIDTH-1:0]   exp_dat [NUMRDPT];
    logic [WIDTH-1:0]   pq_dat  [NUMRDPT];
    logic [BITADDR-1:0] pq_adr  [NUMRDPT];
    logic [NUMWRPT-1:0] wr_en;

    // Serr never changes the verdict; the data must still be right.
    logic unused_serr;
    assign unused_serr = ^rd_serr;

    genvar gi;
    generate
        for (gi = 0; gi < NUMRDPT; gi++) begin : g_rd
            logic [BITADDR-1:0] adr;
            logic               in_range;
            assign adr           = rd_adr[gi*BITADDR +: BITADDR];
            assign in_range      = 32'(adr) < NUMADDR;
            assign push[gi]      = read[gi] & ready;
            assign exp_known[gi] = in_range && written_q[adr];
            assign exp_dat[gi]   = in_range ? mem_q[adr] : '0;

            algo_rd_scoreboard_pipe #(
                .RD_DELAY(RD_DELAY), .BITADDR(BITADDR), .WIDTH(WIDTH)
            ) u_pipe (
                .clk(clk), .rst(rst),
                .push_i(push[gi]), .known_i(exp_known[gi]),
                .adr_i(adr), .dat_i(exp_dat[gi]),
                .vld_o(pq_vld[gi]), .known_o(pq_known[gi]),
                .adr_o(pq_adr[gi]), .dat_o(pq_dat[gi])
            );
        end
        for (gi = 0; gi < NUMWRPT; gi++) begin : g_wr
            assign wr_en[gi] = write[gi] & ready &
                               (32'(wr_adr[gi*BITADDR +: BITADDR]) < NUMADDR);
        end
    endgenerate

    logic [NUMRDPT-1:0] vld_mis, dat_mis;
    logic               req_viol;
    logic [31:0]        ev_n;
    logic [FPW-1:0]     cap_port;
    logic [BITADDR-1:0] cap_adr;
    logic               cap_hit;

    always_comb begin
        vld_mis  = '0;
        dat_mis  = '0;
        ev_n     = '0;
        cap_port = '0;
        cap_adr  = '0;
        cap_hit  = 1'b0;
        req_viol = ~ready & ((|read) | (|write));
        for (int p = 0; p < NUMRDPT; p++) begin
            vld_mis[p] = pq_vld[p] ^ rd_vld[p];
            dat_mis[p] = pq_vld[p] & rd_vld[p] & pq_known[p] & ~rd_derr[p] &
                         (pq_dat[p] != rd_dout[p*WIDTH +: WIDTH]);
            ev_n = ev_n + 32'(vld_mis[p]) + 32'(dat_mis[p]);
        end
        ev_n = ev_n + 32'(req_viol);
        // Descending scans so the lowest index is the one left standing.
        for (int p = NUMRDPT-1; p >= 0; p--) begin
            if (vld_mis[p] | dat_mis[p]) begin
                cap_hit  = 1'b1;
                cap_port = FPW'(p);
                cap_adr  = pq_adr[p];
            end
        end
        if (!cap_hit) begin
            for (int w = NUMWRPT-1; w >= 0; w--)
                if (write[w]) cap_adr = wr_adr[w*BITADDR +: BITADDR];
            for (int p = NUMRDPT-1; p >= 0; p--)
                if (read[p]) cap_adr = rd_adr[p*BITADDR +: BITADDR];
        end
    end

    logic                req_err_q, first_vld_q;
    logic [NUMRDPT-1:0]  vld_err_q, dat_err_q;
    logic [CNTW-1:0]     err_cnt_q, err_cnt_d;
    logic [FPW-1:0]      first_port_q;
    logic [BITADDR-1:0]  first_adr_q;

    assign err_cnt_d = CNTW'(sat_add(32'(err_cnt_q), ev_n, CNTW));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written_q    <= '0;
            req_err_q    <= 1'b0;
            vld_err_q    <= '0;
            dat_err_q    <= '0;
            err_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_port_q <= '0;
            first_adr_q  <= '0;
        end else begin
            for (int w = 0; w < NUMWRPT; w++)
                if (wr_en[w]) written_q[wr_adr[w*BITADDR +: BITADDR]] <= 1'b1;
            req_err_q <= req_err_q | req_viol;
            vld_err_q <= vld_err_q | vld_mis;
            dat_err_q <= dat_err_q | dat_mis;
            err_cnt_q <= err_cnt_d;
            if (!first_vld_q && (ev_n != 0)) begin
                first_vld_q  <= 1'b1;
                first_port_q <= cap_port;
                first_adr_q  <= cap_adr;
            end
        end
    end

    // Ascending order: the highest-indexed port's assignment lands last.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUMWRPT; w++)
            if (wr_en[w]) mem_q[wr_adr[w*BITADDR +: BITADDR]] <= din[w*WIDTH +: WIDTH];
    end

    assign req_err    = req_err_q;
    assign vld_err    = vld_err_q;
    assign dat_err    = dat_err_q;
    assign err_cnt    = err_cnt_q;
    assign first_vld  = first_vld_q;
    assign first_port = first_port_q;
    assign first_adr  = first_adr_q;

endmodule
